multi_input_gate_bank: RTL
==========================

# multi_input_gate_bank

Parametrised successor to the fixed triple 3-input gate IP in the 74-series catalogue: CHANNELS independent INPUTS-wide gates with a run-time selectable logic function. It also replaces the non-synthesisable `#Delay` propagation model with a synthesisable clock-cycle delay line. The block sits in the 74-series IP catalogue for the Basys3 digital-clock labs and is driven by switch/counter logic in the same clock domain.

## Interface
- CHANNELS, 3, number of independent gates (1..16)
- INPUTS, 3, inputs per gate (2..8)
- DELAY_CYCLES, 0, extra pipeline stages modelling propagation delay (0..15)
- FUNC_RESET, 3'b000, function code loaded at reset
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_bits  input  CHANNELS*INPUTS  gate inputs; channel c uses in_bits[c*INPUTS +: INPUTS]
- func_sel  input  3  function code, sampled only when func_load=1
- func_load  input  1  single-cycle strobe to load func_sel
- hold  input  1  freeze pipeline, busy counter and outputs
- y  output  CHANNELS  gate outputs after latency L
- busy  output  1  high while y still reflects the previous function
- err  output  1  one-cycle pulse on rejected func_load

## Operation
- Function codes: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR (odd parity), 101 XNOR. 110 and 111 are invalid.
- Each edge with hold=0:
  - stage 1 captures F(func_reg, channel inputs) for every channel.
  - stages 2..L shift forward.
  - y = stage L.
- Latency L = DELAY_CYCLES+1. DELAY_CYCLES=0 still gives one register.
- Gate evaluation uses func_reg as it stands before the edge. A load on edge k therefore affects the samples taken from edge k+1 onward.
- Valid func_load:
  - on that edge, func_reg takes func_sel and busy_cnt takes L.
  - busy = (busy_cnt != 0).
  - busy_cnt decrements on each edge with hold=0.
- func_load while busy: accepted, counter reloads to L.
- Invalid code: func_reg and busy_cnt are unchanged; err=1 for exactly the following cycle.
- func_load with hold=1:
  - func_reg and busy_cnt still load.
  - the pipeline stays frozen.
  - no decrement happens until hold falls.
- hold=1: stages, y and busy_cnt keep their values; in_bits are ignored. hold does not affect err.
- Reset mid-operation: every stage, y, busy and err clear immediately, and func_reg = FUNC_RESET. A pending busy count is discarded.

## Timing
- Reset values: y=0, busy=0, err=0, func_reg=FUNC_RESET.
  - This holds even for inverting functions: y shows the true function of the inputs only after L edges following reset release.
- Input change on edge k appears on y after edge k+L-1+1, i.e. y updates on edge k+L relative to inputs stable before edge k+1.
- Strictly: y after edge n = F(in sampled at edge n-L+1).
- busy is high from edge k (load) through the cycle ending at edge k+L, which is L cycles with no hold. busy falls on the same edge on which the first fully new-function y appears.
- err is registered, so it appears on the edge after the rejected strobe.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package gate_bank_pkg holds:
  - function code constants (FUNC_AND … FUNC_XNOR) and FUNC_W=3.
  - the is_valid_func check.
  - the combinational reduce function (code, vector) -> bit.
- Sub-module gate_delay_line: a CHANNELS-wide, DEPTH-stage shift register with async reset and hold. It is instantiated once with DEPTH=L.
- Top level holds func_reg, the busy counter ($clog2(16+1) bits), err and the per-channel reduce.

## Test plan
- Reset, then CHANNELS=3, INPUTS=3, DELAY_CYCLES=0, AND; drive channel0=111, channel1=110 -> y[1:0]=01 after 1 edge, busy=0 throughout.
- DELAY_CYCLES=3 (L=4), NOR; drive all inputs 000 at edge 0 -> y stays 0 until edge 4, then y=111 exactly at edge 4.
- Load XOR at edge k with L=4 -> busy high for 4 cycles and low after edge k+4; channel 011 gives y=0 and 111 gives y=1 from edge k+4.
- func_sel=110 with func_load -> err pulses 1 cycle, func_reg unchanged, busy unchanged, y unaffected.
- hold=1 for 5 cycles mid-stream with toggling inputs -> y and busy frozen; on release, resumes with the original sample order and no lost stages.
- Assert rst asynchronously mid-cycle during busy -> y=0, busy=0, err=0 immediately; function reverts to FUNC_RESET.

Source files
------------

// File: rtl/gate_bank_pkg.sv
// Shared definitions for multi_input_gate_bank: function codes, code validity check
// and the per-channel reduce function.
package gate_bank_pkg;

  localparam int FUNC_W     = 3;
  localparam int MAX_INPUTS = 8;

  localparam logic [FUNC_W-1:0] FUNC_AND  = 3'b000;
  localparam logic [FUNC_W-1:0] FUNC_NAND = 3'b001;
  localparam logic [FUNC_W-1:0] FUNC_OR   = 3'b010;
  localparam logic [FUNC_W-1:0] FUNC_NOR  = 3'b011;
  localparam logic [FUNC_W-1:0] FUNC_XOR  = 3'b100;
  localparam logic [FUNC_W-1:0] FUNC_XNOR = 3'b101;

  function automatic logic is_valid_func(input logic [FUNC_W-1:0] code);
    logic ok;
    case (code)
      FUNC_AND, FUNC_NAND, FUNC_OR, FUNC_NOR, FUNC_XOR, FUNC_XNOR: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Only the low n bits of vec take part; the rest are padding up to MAX_INPUTS.
  function automatic logic gate_reduce(input logic [FUNC_W-1:0]     code,
                                       input logic [MAX_INPUTS-1:0] vec,
                                       input int                    n);
    logic r_and;
    logic r_or;
    logic r_xor;
    logic res;
    r_and = 1'b1;
    r_or  = 1'b0;
    r_xor = 1'b0;
    for (int i = 0; i < MAX_INPUTS; i++) begin
      if (i < n) begin
        r_and = r_and & vec[i];
        r_or  = r_or  | vec[i];
        r_xor = r_xor ^ vec[i];
      end
    end
    case (code)
      FUNC_AND:  res = r_and;
      FUNC_NAND: res = ~r_and;
      FUNC_OR:   res = r_or;
      FUNC_NOR:  res = ~r_or;
      FUNC_XOR:  res = r_xor;
      FUNC_XNOR: res = ~r_xor;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_bank_delay_line.sv
// gate_delay_line: WIDTH-wide, DEPTH-stage shift register with async reset and hold.
module gate_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  // Shift one stage per unheld edge; hold freezes every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else if (!hold) begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/multi_input_gate_bank.sv
// multi_input_gate_bank: CHANNELS run-time-selectable INPUTS-wide gates with a
// clocked propagation delay of DELAY_CYCLES+1 edges.
module multi_input_gate_bank
  import gate_bank_pkg::*;
#(
  parameter int                CHANNELS     = 3,
  parameter int                INPUTS       = 3,
  parameter int                DELAY_CYCLES = 0,
  parameter logic [FUNC_W-1:0] FUNC_RESET   = 3'b000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*INPUTS-1:0]   in_bits,
  input  logic [FUNC_W-1:0]            func_sel,
  input  logic                         func_load,
  input  logic                         hold,
  output logic [CHANNELS-1:0]          y,
  output logic                         busy,
  output logic                         err
);

  localparam int LAT   = DELAY_CYCLES + 1;
  localparam int CNT_W = $clog2(16 + 1);

  logic [FUNC_W-1:0]   func_reg;
  logic [CNT_W-1:0]    busy_cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic                load_ok;
  logic [CHANNELS-1:0] gate_out;

  // A load is only honoured for one of the six defined codes.
  always_comb begin
    load_ok = func_load && is_valid_func(func_sel);
  end

  // A load (even under hold) reloads the full latency; otherwise count down on unheld edges.
  always_comb begin
    cnt_next = busy_cnt;
    if (load_ok) begin
      cnt_next = CNT_W'(LAT);
    end else if (!hold && (busy_cnt != '0)) begin
      cnt_next = busy_cnt - CNT_W'(1);
    end else begin
      cnt_next = busy_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_reg <= FUNC_RESET;
      busy_cnt <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (load_ok) begin
        func_reg <= func_sel;
      end
      busy_cnt <= cnt_next;
      busy     <= (cnt_next != '0);
      err      <= func_load && !is_valid_func(func_sel);
    end
  end

  // Gates evaluate with the function in force before the edge.
  always_comb begin
    gate_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      gate_out[c] = gate_reduce(func_reg, MAX_INPUTS'(in_bits[c*INPUTS +: INPUTS]), INPUTS);
    end
  end

  gate_delay_line #(
    .WIDTH (CHANNELS),
    .DEPTH (LAT)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .hold (hold),
    .din  (gate_out),
    .dout (y)
  );

endmodule
